// File: rtl/shift_issue_stage.sv
// Registered issue stage feeding the 32-bit barrel shifter.
// Decodes R-type shift functs into amount/mode and passes them through a
// two-entry skid buffer. The main register drives the outputs and the skid
// register absorbs one op when downstream stalls.
module shift_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [4:0]       shamt,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic [4:0]       rd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic             aluc1,
    output logic             aluc0,
    output logic [4:0]       rd_out,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [4:0]  amt;
        logic [31:0] data;
        logic [1:0]  aluc;
        logic [4:0]  rd;
    } op_t;

    op_t              main_reg;
    op_t              skid_reg;
    logic             main_valid_reg;
    logic             skid_valid_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] issued_cnt_reg;
    logic [CNT_W-1:0] illegal_cnt_reg;

    logic             dec_legal;
    op_t              dec_op;
    logic             in_xfer;
    logic             out_xfer;
    logic             acc_legal;
    logic             acc_illegal;

    // Decode funct into shift amount source and shifter mode.
    always_comb begin
        dec_legal   = 1'b1;
        dec_op.amt  = shamt;
        dec_op.data = rt_data;
        dec_op.aluc = 2'b00;
        dec_op.rd   = rd_in;
        case (funct)
            6'b000000: dec_op.aluc = 2'b10;
            6'b000010: dec_op.aluc = 2'b01;
            6'b000011: dec_op.aluc = 2'b00;
            6'b000100: begin dec_op.amt = rs_data[4:0]; dec_op.aluc = 2'b10; end
            6'b000110: begin dec_op.amt = rs_data[4:0]; dec_op.aluc = 2'b01; end
            6'b000111: begin dec_op.amt = rs_data[4:0]; dec_op.aluc = 2'b00; end
            default:   dec_legal = 1'b0;
        endcase
    end

    // in_ready comes straight from the skid flag, so it never sees out_ready.
    assign in_ready    = !skid_valid_reg;
    assign in_xfer     = in_valid && in_ready;
    assign out_xfer    = main_valid_reg && out_ready;
    assign acc_legal   = in_xfer && dec_legal && !flush;
    assign acc_illegal = in_xfer && !dec_legal && !flush;

    // Skid buffer state, illegal pulse and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_reg        <= '0;
            skid_reg        <= '0;
            main_valid_reg  <= 1'b0;
            skid_valid_reg  <= 1'b0;
            illegal_reg     <= 1'b0;
            issued_cnt_reg  <= '0;
            illegal_cnt_reg <= '0;
        end else if (flush) begin
            // An op leaving on the flush edge was really delivered.
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            illegal_reg    <= 1'b0;
            if (out_xfer) begin
                issued_cnt_reg <= issued_cnt_reg + 1'b1;
            end
        end else begin
            illegal_reg <= acc_illegal;
            if (acc_illegal) begin
                illegal_cnt_reg <= illegal_cnt_reg + 1'b1;
            end
            if (out_xfer) begin
                issued_cnt_reg <= issued_cnt_reg + 1'b1;
                if (skid_valid_reg) begin
                    // in_ready is low here, so nothing new can arrive.
                    main_reg       <= skid_reg;
                    skid_valid_reg <= 1'b0;
                end else begin
                    main_valid_reg <= acc_legal;
                    if (acc_legal) begin
                        main_reg <= dec_op;
                    end
                end
            end else if (acc_legal) begin
                if (!main_valid_reg) begin
                    main_reg       <= dec_op;
                    main_valid_reg <= 1'b1;
                end else begin
                    skid_reg       <= dec_op;
                    skid_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign out_valid   = main_valid_reg;
    assign A           = {27'b0, main_reg.amt};
    assign B           = main_reg.data;
    assign aluc1       = main_reg.aluc[1];
    assign aluc0       = main_reg.aluc[0];
    assign rd_out      = main_reg.rd;
    assign illegal     = illegal_reg;
    assign issued_cnt  = issued_cnt_reg;
    assign illegal_cnt = illegal_cnt_reg;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scoreboard bench for shift_issue_stage: accepted legal ops are queued,
// and the queue is checked against the DUT outputs every cycle.
module tb_shift_issue_stage;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready;
    logic [5:0]       funct;
    logic [4:0]       shamt, rd_in, rd_out;
    logic [31:0]      rs_data, rt_data, A, B;
    logic             out_valid, out_ready, aluc1, aluc0, illegal;
    logic [CNT_W-1:0] issued_cnt, illegal_cnt;

    always #5 clk = ~clk;

    shift_issue_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .shamt(shamt), .rs_data(rs_data), .rt_data(rt_data),
        .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .aluc1(aluc1), .aluc0(aluc0), .rd_out(rd_out),
        .illegal(illegal), .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt)
    );

    typedef struct packed {
        logic [4:0]  amt;
        logic [31:0] data;
        logic [1:0]  aluc;
        logic [4:0]  rd;
    } op_t;

    op_t  sb_q[$];
    op_t  sb_head;
    int   checks = 0;
    int   errors = 0;
    int   m_issued = 0;
    int   m_illegal = 0;
    logic m_pulse = 1'b0;
    bit   started = 1'b0;
    bit   m_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_shift(input logic [5:0] f);
        return (f == 6'd0) || (f == 6'd2) || (f == 6'd3) ||
               (f == 6'd4) || (f == 6'd6) || (f == 6'd7);
    endfunction

    // Expected op: funct[2] picks variable shifts, funct[1:0] picks the mode.
    function automatic op_t model_op(input logic [5:0] f, input logic [4:0] sh,
                                     input logic [31:0] rs, input logic [31:0] rt,
                                     input logic [4:0] rd);
        op_t o;
        o.amt  = f[2] ? rs[4:0] : sh;
        o.data = rt;
        o.rd   = rd;
        case (f[1:0])
            2'b00:   o.aluc = 2'b10;
            2'b10:   o.aluc = 2'b01;
            default: o.aluc = 2'b00;
        endcase
        return o;
    endfunction

    // Compare state against the model, then advance the model past the next edge.
    always @(negedge clk) begin
        if (started) begin
            check("out_valid", out_valid, sb_q.size() > 0);
            check("in_ready", in_ready, sb_q.size() < 2);
            check("illegal", illegal, m_pulse);
            check("issued_cnt", issued_cnt, m_issued[CNT_W-1:0]);
            check("illegal_cnt", illegal_cnt, m_illegal[CNT_W-1:0]);
            if (sb_q.size() > 0) begin
                sb_head = sb_q[0];
                check("A", A, {27'b0, sb_head.amt});
                check("B", B, sb_head.data);
                check("aluc", {aluc1, aluc0}, sb_head.aluc);
                check("rd_out", rd_out, sb_head.rd);
            end
        end
        if (rst) begin
            sb_q.delete();
            m_issued  = 0;
            m_illegal = 0;
            m_pulse   = 1'b0;
            started   = 1'b1;
        end else if (started) begin
            m_acc = in_valid && (sb_q.size() < 2) && !flush;
            if ((sb_q.size() > 0) && out_ready) begin
                sb_head = sb_q.pop_front();
                m_issued++;
                $display("xfer A=%0d B=%08h aluc=%0b rd=%0d", sb_head.amt, sb_head.data,
                         sb_head.aluc, sb_head.rd);
            end
            if (flush) begin
                sb_q.delete();
                m_pulse = 1'b0;
            end else begin
                m_pulse = m_acc && !is_shift(funct);
                if (m_acc && !is_shift(funct)) m_illegal++;
                if (m_acc && is_shift(funct))
                    sb_q.push_back(model_op(funct, shamt, rs_data, rt_data, rd_in));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one op and hold it until accepted (bounded).
    task automatic send(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [4:0] rd);
        bit acc = 1'b0;
        in_valid = 1'b1; funct = f; shamt = sh; rs_data = rs; rt_data = rt; rd_in = rd;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        funct = '0; shamt = '0; rs_data = '0; rt_data = '0; rd_in = '0;
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_rd", rd_out, 0);
        check("rst_in_ready", in_ready, 1);
        cyc(1);

        // SLL immediate
        out_ready = 1'b1;
        send(6'b000000, 5'd4, 32'h0, 32'h0000_00F1, 5'd3);
        @(negedge clk);
        check("sll_valid", out_valid, 1);
        check("sll_A", A, 32'd4);
        check("sll_B", B, 32'h0000_00F1);
        check("sll_aluc", {aluc1, aluc0}, 2'b10);
        cyc(1);
        @(negedge clk);
        check("sll_issued", issued_cnt, 1);
        cyc(1);

        // SRAV: only rs[4:0] is used as the amount
        send(6'b000111, 5'd9, 32'hFFFF_FFE3, 32'h8000_0000, 5'd5);
        @(negedge clk);
        check("srav_A", A, 32'd3);
        check("srav_B", B, 32'h8000_0000);
        check("srav_aluc", {aluc1, aluc0}, 2'b00);
        cyc(2);

        // Back-pressure: two buffered, third stalls upstream
        out_ready = 1'b0;
        fork
            begin
                send(6'b000010, 5'd7, 32'h0, 32'h1234_5678, 5'd1);
                send(6'b000100, 5'd0, 32'h0000_0029, 32'hA5A5_A5A5, 5'd2);
                send(6'b000011, 5'd31, 32'h0, 32'hF000_000F, 5'd4);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_in_ready", in_ready, 0);
                check("bp_A_held", A, 32'd7);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        cyc(4);
        @(negedge clk);
        check("bp_issued_wrap", issued_cnt, 2'd1);
        cyc(1);

        // Illegal funct (ADD)
        send(6'b100000, 5'd1, 32'h0, 32'h0, 5'd6);
        @(negedge clk);
        check("ill_pulse", illegal, 1);
        check("ill_no_valid", out_valid, 0);
        @(negedge clk);
        check("ill_pulse_end", illegal, 0);
        check("ill_cnt", illegal_cnt, 1);
        cyc(1);
        send(6'b000110, 5'd0, 32'h0000_0011, 32'h0F0F_0F0F, 5'd7);
        cyc(3);

        // Flush with main and skid full, op offered
        out_ready = 1'b0;
        send(6'b000000, 5'd1, 32'h0, 32'h1, 5'd8);
        send(6'b000010, 5'd2, 32'h0, 32'h2, 5'd9);
        flush = 1'b1; in_valid = 1'b1; funct = 6'b000011; shamt = 5'd5; rt_data = 32'h3;
        cyc(1);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_issued", issued_cnt, 2'd2);
        check("fl_ill_cnt", illegal_cnt, 1);
        cyc(1);

        // Flush with only main full and an out transfer on the flush edge
        send(6'b000100, 5'd0, 32'h6, 32'h4, 5'd10);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; funct = 6'b000000; shamt = 5'd9;
        cyc(1);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl2_valid", out_valid, 0);
        check("fl2_issued", issued_cnt, 2'd3);
        cyc(2);

        // Reset mid-stall
        out_ready = 1'b0;
        send(6'b000111, 5'd0, 32'h1F, 32'h55, 5'd11);
        send(6'b000011, 5'd3, 32'h0, 32'h66, 5'd12);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check("rr_valid", out_valid, 0);
        check("rr_in_ready", in_ready, 1);
        check("rr_A", A, 0);
        check("rr_B", B, 0);
        check("rr_aluc", {aluc1, aluc0}, 0);
        check("rr_rd", rd_out, 0);
        check("rr_issued", issued_cnt, 0);
        check("rr_ill_cnt", illegal_cnt, 0);
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Registered issue stage directly upstream of the 32-bit barrel shifter in the MIPS CPU execute path.
- Accepts decoded R-type shift instructions and selects the shift amount: immediate shamt or rs[4:0].
- Drives the shifter's A (amount), B (data) and aluc1/aluc0 operands through a 2-entry skid buffer with valid/ready handshakes.
- Rejects non-shift functs and counts both issued and rejected operations.

Parameters:
- CNT_W, 16, width of the issued-op and illegal-op counters.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all buffered ops this cycle
- in_valid  input  1  upstream offers an op
- in_ready  output  1  stage can accept an op
- funct  input  6  R-type funct field
- shamt  input  5  instruction shamt field
- rs_data  input  32  rs register value
- rt_data  input  32  rt register value
- rd_in  input  5  destination register
- out_valid  output  1  A/B/aluc/rd_out hold a valid op
- out_ready  input  1  downstream (shifter/EX latch) consumes op
- A  output  32  shift amount to shifter, bits [31:5] always 0
- B  output  32  data to be shifted (= rt_data)
- aluc1  output  1  shifter mode bit 1
- aluc0  output  1  shifter mode bit 0
- rd_out  output  5  destination register passed along
- illegal  output  1  one-cycle pulse: non-shift funct was accepted and dropped
- issued_cnt  output  CNT_W  ops delivered downstream
- illegal_cnt  output  CNT_W  ops dropped as illegal

Behaviour:
- Decode funct to amount source and mode:
  - 000000 SLL: A={27'b0,shamt}, aluc=10.
  - 000010 SRL: A={27'b0,shamt}, aluc=01.
  - 000011 SRA: A={27'b0,shamt}, aluc=00.
  - 000100 SLLV: A={27'b0,rs_data[4:0]}, aluc=10.
  - 000110 SRLV: A={27'b0,rs_data[4:0]}, aluc=01.
  - 000111 SRAV: A={27'b0,rs_data[4:0]}, aluc=00.
  - Any other funct is illegal.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Storage is a main register (drives outputs) plus one skid register.
- in_ready = !skid_valid. It is registered and never depends combinationally on out_ready.
- Accepted legal op:
  - goes to main if main is empty or main is transferring out this cycle;
  - otherwise goes to skid.
- Out transfer while skid is valid: skid moves to main in the same edge; skid clears unless a new op lands in skid on that edge.
- Ordering is strictly FIFO; an op is never duplicated or lost.
- Latency: accepted op is visible on outputs the next cycle when main is empty. Throughput is 1 op/cycle with out_ready held high.
- Illegal accepted op:
  - writes no entry;
  - illegal=1 for the following cycle;
  - illegal_cnt increments.
- issued_cnt increments on every out transfer. Both counters wrap from all-ones to 0.
- While out_valid=1 and out_ready=0, A/B/aluc/rd_out hold stable.
- flush:
  - clears main and skid valid on that edge;
  - drops any op offered the same cycle (not counted, no illegal pulse);
  - an out transfer in the flush cycle still counts as issued;
  - counters are otherwise retained.
- rst (sync) zeroes everything:
  - out_valid, A, B, aluc1, aluc0, rd_out, illegal, issued_cnt, illegal_cnt, skid contents;
  - in_ready=1 from the first cycle after reset;
  - reset mid-operation discards buffered ops without counting them.
- Priority: rst > flush > normal operation.

Test Plan:
- SLL with shamt=4, rt=0x0000_00F1, out_ready=1 -> next cycle out_valid=1, A=4, B=0x0000_00F1, aluc=10; issued_cnt=1 after transfer.
- SRAV with rs=0xFFFF_FFE3, rt=0x8000_0000 -> A=0x0000_0003 (upper bits masked), aluc=00, B=0x8000_0000.
- Back-pressure sequence:
  - out_ready=0, then three back-to-back ops SRL/SLLV/SRA -> first two held (main+skid), in_ready=0 after the second, third stalls upstream;
  - then raise out_ready -> all three emerge in order on consecutive cycles; issued_cnt=3.
- funct=100000 (ADD) accepted -> no out_valid, illegal pulse for exactly one cycle, illegal_cnt=1, next legal op unaffected.
- Main and skid full; assert flush with a new op offered -> out_valid=0, in_ready=1 next cycle, offered op not delivered, counters unchanged.
- Counter wrap with CNT_W=2, five issued ops -> issued_cnt=1. Then assert rst mid-stall -> all outputs 0, in_ready=1 next cycle.
